// File: rtl/code_bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : code_bcd_pkg
//  Description : Shared definitions for the coded-digit BCD packer.
//                Holds the packer state enum, the 4-bit code assigned to each
//                decimal digit 1..9, and width helpers for the packed BCD
//                word and the optional binary accumulator.
//                The binary accumulator only exists when CODE_BCD_BIN_OUT_EN
//                is defined.
//  Revision    : 1.0  initial release
// ============================================================================
package code_bcd_pkg;

    // Packer state: collecting digits, or holding a finished word.
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    // 4-bit codes for digits 1..9; every other code is invalid.
    localparam logic [3:0] c_code_1 = 4'b0111;
    localparam logic [3:0] c_code_2 = 4'b0110;
    localparam logic [3:0] c_code_3 = 4'b0101;
    localparam logic [3:0] c_code_4 = 4'b0100;
    localparam logic [3:0] c_code_5 = 4'b1011;
    localparam logic [3:0] c_code_6 = 4'b1010;
    localparam logic [3:0] c_code_7 = 4'b1001;
    localparam logic [3:0] c_code_8 = 4'b1000;
    localparam logic [3:0] c_code_9 = 4'b1111;

    // Packed BCD word width: one nibble per digit.
    function automatic int bcd_width(input int digits);
        return 4 * digits;
    endfunction

    // Width needed to hold any value of 'digits' decimal digits.
    function automatic int bin_width(input int digits);
        return $clog2(10 ** digits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/code_digit_dec.sv
`default_nettype none
// ============================================================================
//  Module      : code_digit_dec
//  Description : Combinational decoder from the 4-bit digit code to a BCD
//                digit. Unknown codes decode to 0 with o_invalid set.
//  Ports       : i_code    [3:0]  coded digit
//                o_digit   [3:0]  decoded BCD digit (0 when invalid)
//                o_invalid        code is not one of the nine digit codes
//  Revision    : 1.0  initial release
// ============================================================================
module code_digit_dec
    import code_bcd_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [3:0] o_digit,
    output logic       o_invalid
);

    always_comb begin
        o_digit   = 4'd0;
        o_invalid = 1'b0;
        case (i_code)
            c_code_1: o_digit = 4'd1;
            c_code_2: o_digit = 4'd2;
            c_code_3: o_digit = 4'd3;
            c_code_4: o_digit = 4'd4;
            c_code_5: o_digit = 4'd5;
            c_code_6: o_digit = 4'd6;
            c_code_7: o_digit = 4'd7;
            c_code_8: o_digit = 4'd8;
            c_code_9: o_digit = 4'd9;
            default:  o_invalid = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/code_bcd_packer.sv
`default_nettype none
// ============================================================================
//  Module      : code_bcd_packer
//  Description : Collects coded decimal digits one at a time and packs them
//                into a BCD word, most significant digit first. A word is
//                closed when DIGITS digits have arrived or on flush, then
//                held on the output until out_ready accepts it.
//                Optional build macro CODE_BCD_BIN_OUT_EN adds out_bin, the
//                binary value of the same digits.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                in_code/in_valid/in_ready  digit input handshake
//                flush             close a partial word early
//                out_bcd/out_cnt/out_err    held word, digit count,
//                                  sticky invalid-code flag
//                out_valid/out_ready        word output handshake
//                out_bin           binary value (CODE_BCD_BIN_OUT_EN only)
//  Revision    : 1.0  initial release
// ============================================================================
module code_bcd_packer
    import code_bcd_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int W_BCD  = bcd_width(DIGITS),
    localparam int W_CNT  = $clog2(DIGITS + 1)
`ifdef CODE_BCD_BIN_OUT_EN
    ,
    localparam int W_BIN  = bin_width(DIGITS)
`endif
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_code,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [W_BCD-1:0] out_bcd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_err,
    output logic [W_CNT-1:0] out_cnt
`ifdef CODE_BCD_BIN_OUT_EN
    ,
    output logic [W_BIN-1:0] out_bin
`endif
);

    localparam logic [0:0]       c_st_collect = 1'(COLLECT);
    localparam logic [0:0]       c_st_hold    = 1'(HOLD);
    localparam logic [W_CNT-1:0] c_cnt_last   = W_CNT'(DIGITS - 1);

    logic [0:0]       r_state;
    logic [W_BCD-1:0] r_bcd;
    logic [W_CNT-1:0] r_cnt;
    logic             r_err;

    logic [3:0]       w_digit;
    logic             w_invalid;
    logic [W_BCD-1:0] w_bcd_shift;
    logic             w_xfer;
    logic             w_close;

    code_digit_dec u_dec (
        .i_code    (in_code),
        .o_digit   (w_digit),
        .o_invalid (w_invalid)
    );

    // A single-digit word has no older nibbles to keep.
    if (DIGITS == 1) begin : g_shift_single
        assign w_bcd_shift = w_digit;
    end else begin : g_shift_multi
        assign w_bcd_shift = {r_bcd[W_BCD-5:0], w_digit};
    end

    assign in_ready  = (r_state == c_st_collect);
    assign out_valid = (r_state == c_st_hold);
    assign w_xfer    = in_valid && in_ready;

    // Close on the digit that fills the word, or on flush when the word
    // (including a digit arriving this same cycle) is non-empty.
    assign w_close = in_ready &&
                     ((w_xfer && ((r_cnt == c_cnt_last) || flush)) ||
                      (flush && (r_cnt != '0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_collect;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_collect: begin
                    if (w_xfer) begin
                        r_bcd <= w_bcd_shift;
                        r_cnt <= r_cnt + W_CNT'(1);
                        r_err <= r_err | w_invalid;
                    end
                    if (w_close) begin
                        r_state <= c_st_hold;
                    end
                end
                c_st_hold: begin
                    if (out_ready) begin
                        r_state <= c_st_collect;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= c_st_collect;
            endcase
        end
    end

    assign out_bcd = r_bcd;
    assign out_cnt = r_cnt;
    assign out_err = r_err;

`ifdef CODE_BCD_BIN_OUT_EN
    logic [W_BIN-1:0] r_bin;
    logic [W_BIN-1:0] w_bin_next;

    // bin*10 + digit; never exceeds 10**DIGITS-1 so W_BIN bits suffice.
    assign w_bin_next = (r_bin << 3) + (r_bin << 1) + W_BIN'(w_digit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin <= '0;
        end else if (w_xfer) begin
            r_bin <= w_bin_next;
        end else if (out_valid && out_ready) begin
            r_bin <= '0;
        end
    end

    assign out_bin = r_bin;
`endif

endmodule
`default_nettype wire

// File: tb/tb_code_bcd_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_code_bcd_packer
//  Description : Self-checking bench for code_bcd_packer (DIGITS=4).
//                Directed word sequences followed by random traffic, all
//                compared against a word-level reference model; the digit
//                decoder is also swept over all 16 codes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_code_bcd_packer;

    localparam int DIGITS = 4;
    localparam int W_BCD  = 4 * DIGITS;
    localparam int W_CNT  = $clog2(DIGITS + 1);
`ifdef CODE_BCD_BIN_OUT_EN
    localparam int W_BIN  = $clog2(10 ** DIGITS);
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       in_code;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [W_BCD-1:0] out_bcd;
    logic             out_valid;
    logic             out_ready;
    logic             out_err;
    logic [W_CNT-1:0] out_cnt;
`ifdef CODE_BCD_BIN_OUT_EN
    logic [W_BIN-1:0] out_bin;
`endif

    logic [3:0] d_code;
    logic [3:0] d_digit;
    logic       d_inv;

    always #5 clk = ~clk;

    code_bcd_packer #(.DIGITS(DIGITS)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_code   (in_code),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_bcd   (out_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err),
        .out_cnt   (out_cnt)
`ifdef CODE_BCD_BIN_OUT_EN
        ,
        .out_bin   (out_bin)
`endif
    );

    code_digit_dec u_dec (
        .i_code    (d_code),
        .o_digit   (d_digit),
        .o_invalid (d_inv)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Digit table from the code definition; -1 marks an invalid code.
    function automatic int spec_digit(input logic [3:0] c);
        case (c)
            4'b0111: return 1;
            4'b0110: return 2;
            4'b0101: return 3;
            4'b0100: return 4;
            4'b1011: return 5;
            4'b1010: return 6;
            4'b1001: return 7;
            4'b1000: return 8;
            4'b1111: return 9;
            default: return -1;
        endcase
    endfunction

    // Reference model: list of accepted codes plus a "word is held" flag.
    bit         m_hold;
    logic [3:0] m_codes[$];
    longint     exp_bcd, exp_bin, exp_cnt;
    bit         exp_err;

    function automatic void model_close();
        int d;
        exp_bcd = 0;
        exp_bin = 0;
        exp_err = 0;
        foreach (m_codes[i]) begin
            d = spec_digit(m_codes[i]);
            if (d < 0) begin
                exp_err = 1;
                d = 0;
            end
            exp_bcd = exp_bcd * 16 + d;
            exp_bin = exp_bin * 10 + d;
        end
        exp_cnt = m_codes.size();
        m_hold  = 1;
    endfunction

    function automatic void model_clear();
        m_codes.delete();
        m_hold = 0;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model,
    // advance the clock, then advance the model.
    task automatic cycle(input bit r, input bit iv, input logic [3:0] code,
                         input bit fl, input bit ordy);
        rst       = r;
        in_valid  = iv;
        in_code   = code;
        flush     = fl;
        out_ready = ordy;
        #1;
        check_eq("in_ready", in_ready, !m_hold);
        check_eq("out_valid", out_valid, m_hold);
        if (m_hold) begin
            check_eq("out_bcd", out_bcd, exp_bcd);
            check_eq("out_cnt", out_cnt, exp_cnt);
            check_eq("out_err", out_err, exp_err);
`ifdef CODE_BCD_BIN_OUT_EN
            check_eq("out_bin", out_bin, exp_bin);
`endif
        end else if (m_codes.size() == 0) begin
            check_eq("idle_bcd", out_bcd, 0);
            check_eq("idle_cnt", out_cnt, 0);
            check_eq("idle_err", out_err, 0);
`ifdef CODE_BCD_BIN_OUT_EN
            check_eq("idle_bin", out_bin, 0);
`endif
        end
        @(posedge clk);
        #1;
        if (r) begin
            model_clear();
        end else if (!m_hold) begin
            if (iv) m_codes.push_back(code);
            if (m_codes.size() == DIGITS || (fl && m_codes.size() > 0)) model_close();
        end else if (ordy) begin
            model_clear();
        end
    endtask

    task automatic send_word(input logic [3:0] c0, input logic [3:0] c1,
                             input logic [3:0] c2, input logic [3:0] c3);
        cycle(0, 1, c0, 0, 1);
        cycle(0, 1, c1, 0, 1);
        cycle(0, 1, c2, 0, 1);
        cycle(0, 1, c3, 0, 1);
    endtask

    initial begin
        int n_inv;
        rst = 1; in_valid = 0; in_code = 0; flush = 0; out_ready = 0; d_code = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_clear();

        // Reset state, held with traffic present.
        cycle(1, 1, 4'b0111, 1, 1);
        cycle(0, 0, 4'b0000, 0, 1);

        // Plain word 1234, accepted immediately.
        send_word(4'b0111, 4'b0110, 4'b0101, 4'b0100);
        cycle(0, 0, 4'b0000, 0, 1);
        cycle(0, 0, 4'b0000, 0, 1);

        // Word with an invalid code in the middle: 9085, err set.
        send_word(4'b1111, 4'b0000, 4'b1000, 4'b1011);
        cycle(0, 0, 4'b0000, 0, 1);

        // Back-pressure: word 5678 held for 5 cycles while digits are offered.
        send_word(4'b1011, 4'b1010, 4'b1001, 4'b1000);
        for (int i = 0; i < 5; i++) cycle(0, 1, 4'b0111, 0, 0);
        cycle(0, 1, 4'b0111, 0, 1);
        send_word(4'b0100, 4'b0101, 4'b0110, 4'b0111);
        cycle(0, 0, 4'b0000, 0, 1);

        // Flush together with the second digit: 0019; then empty flushes.
        cycle(0, 1, 4'b0111, 0, 1);
        cycle(0, 1, 4'b1111, 1, 0);
        cycle(0, 0, 4'b0000, 1, 0);
        cycle(0, 0, 4'b0000, 1, 1);
        cycle(0, 0, 4'b0000, 1, 1);
        cycle(0, 0, 4'b0000, 1, 1);

        // Reset mid-word, and reset while a word is held.
        cycle(0, 1, 4'b1111, 0, 1);
        cycle(0, 1, 4'b1111, 0, 1);
        cycle(0, 1, 4'b1111, 0, 1);
        cycle(1, 1, 4'b1111, 1, 1);
        cycle(0, 0, 4'b0000, 0, 1);
        cycle(0, 1, 4'b1001, 0, 0);
        cycle(0, 1, 4'b1001, 0, 0);
        cycle(0, 1, 4'b1001, 0, 0);
        cycle(0, 1, 4'b1001, 0, 0);
        cycle(0, 0, 4'b0000, 0, 0);
        cycle(1, 0, 4'b0000, 0, 1);
        cycle(0, 0, 4'b0000, 0, 0);
        send_word(4'b0111, 4'b1000, 4'b0110, 4'b1001);
        cycle(0, 0, 4'b0000, 0, 1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 1) == 1));
        end

        // Decoder sweep over all 16 codes.
        n_inv = 0;
        for (int c = 0; c < 16; c++) begin
            int d;
            d_code = 4'(c);
            #1;
            d = spec_digit(4'(c));
            check_eq("dec_invalid", d_inv, (d < 0));
            check_eq("dec_digit", d_digit, (d < 0) ? 0 : d);
            if (d_inv) n_inv++;
        end
        check_eq("dec_invalid_count", n_inv, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/code_bcd_packer.md
CODE_BCD_PACKER -- requirements
Module: code_bcd_packer

Interface
REQ-001 Parameter DIGITS, default 4, number of coded digits packed per output word (legal range 1..8).
REQ-002 Parameter W_BCD, default 4*DIGITS, packed BCD word width (derived, not overridable).
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port in_code  input  4  coded digit, using the team's 4-bit digit code (table in REQ-011).
REQ-006 Port in_valid  input  1  in_code is valid this cycle.
REQ-007 Port in_ready  output  1  block accepts in_code this cycle.
REQ-008 Port flush  input  1  close the current word early.
REQ-009 Port out_bcd  output  W_BCD  packed BCD word, most significant digit first.
REQ-010 Port out_valid, out_ready, out_err, out_cnt  output/input/output/output  1/1/1/$clog2(DIGITS+1)  word handshake, sticky invalid-code flag, digits held in the word.

Function
REQ-011 Decode table SHALL be: 0111->1, 0110->2, 0101->3, 0100->4, 1011->5, 1010->6, 1001->7, 1000->8, 1111->9; every other code is invalid and decodes to 0.
REQ-012 The transfer SHALL complete when in_valid && in_ready are both high at a rising edge.
REQ-013 On each transfer the shift register SHALL update as bcd <= {bcd[W_BCD-5:0], digit} and cnt <= cnt+1.
REQ-014 An invalid code SHALL still be accepted, shift in 0 and set the word's err flag.
REQ-015 States: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 COLLECT->HOLD SHALL occur on the transfer that makes cnt==DIGITS; out_valid rises the next cycle (latency 1 cycle from last digit).
REQ-017 COLLECT->HOLD SHALL occur on flush=1 with cnt>0; a flush in the same cycle as a transfer includes that digit; flush with cnt==0 and no transfer is ignored.
REQ-018 Partial words SHALL be right-aligned with zero upper digits.
REQ-019 In HOLD, out_bcd/out_err/out_cnt SHALL be stable until out_valid && out_ready.
REQ-020 On that handshake the block SHALL return to COLLECT with bcd=0, cnt=0, err=0.
REQ-021 in_ready SHALL be low in HOLD, with no same-cycle pass-through.
REQ-022 flush in HOLD SHALL be ignored.

Reset
REQ-023 rst=1 SHALL force COLLECT with out_bcd=0, out_valid=0, out_err=0, out_cnt=0 and in_ready=1 (and out_bin=0 when REQ-025 is compiled in) on the next edge, discarding any partial or held word.
REQ-024 rst SHALL take priority over transfer, flush and output handshake in the same cycle.

Configuration
REQ-025 Macro CODE_BCD_BIN_OUT_EN defined SHALL add an output out_bin of width $clog2(10**DIGITS) that accumulates bin <= bin*10 + digit per transfer and follows the same reset, hold and clear rules.
REQ-026 Without CODE_BCD_BIN_OUT_EN the port out_bin and its multiplier logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-027 A shared package code_bcd_pkg SHALL hold the state enum (COLLECT, HOLD), the 4-bit code constants for digits 1..9 and the function for the W_BCD width.
REQ-028 One sub-module code_digit_dec SHALL hold the combinational decoder: in 4-bit code, out 4-bit digit plus 1-bit invalid.
REQ-029 The packer SHALL instantiate code_digit_dec once.

Verification (DIGITS=4, BIN_OUT_EN defined)
REQ-030 Stream 0111,0110,0101,0100 with out_ready=1 -> one cycle after the 4th digit: out_bcd=16'h1234, out_bin=1234, out_cnt=4, out_err=0, then the next cycle shows out_valid=0 and in_ready=1.
REQ-031 Stream 1111,0000,1000,1011 -> out_bcd=16'h9085, out_err=1, out_bin=9085.
REQ-032 Hold out_ready=0 for 5 cycles after a full word and drive in_valid=1 -> in_ready=0, out_bcd stable over 5 cycles, no digit lost; then raise out_ready and send the next word, which completes correctly.
REQ-033 Send 0111 then 1111 with flush in the same cycle as 1111 -> out_bcd=16'h0019, out_cnt=2, out_bin=19; flush with cnt==0 -> no output.
REQ-034 Assert rst after 3 digits and after a word reaches HOLD -> all outputs 0, COLLECT; a following 4-digit word decodes cleanly without residue.
REQ-035 Drive all 16 codes through code_digit_dec -> exactly 7 codes flagged invalid, and the others match REQ-011.
